// File: rtl/mul_16bit_booth_ppgen.sv
// Two-stage radix-4 Booth partial-product generator feeding the 8-input Wallace column array.
// Optional transfer counter on o_cnt when MUL_PPGEN_CNT_EN is defined.
module mul_16bit_booth_ppgen (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_vld,
    output logic         o_rdy,
    input  logic [15:0]  i_num_a,
    input  logic [15:0]  i_num_b,
    output logic         o_vld,
    input  logic         i_rdy,
    output logic [255:0] o_pp
`ifdef MUL_PPGEN_CNT_EN
    ,
    output logic [15:0]  o_cnt
`endif
);

    logic             r_s1_vld;
    logic [17:0]      r_s1_a;
    logic [7:0][2:0]  r_s1_dig;
    logic             r_o_vld;
    logic [255:0]     r_pp;

    logic             w_s2_load;
    logic             w_in_xfer;
    logic [16:0]      w_b_ext;
    logic [7:0][2:0]  w_dig;
    logic [17:0]      w_a2;
    logic [7:0][17:0] w_mult;
    logic [7:0][31:0] w_pp;

    assign w_s2_load = !r_o_vld || i_rdy;
    assign o_rdy     = !i_rst && (!r_s1_vld || w_s2_load);
    assign w_in_xfer = i_vld && o_rdy;
    assign o_vld     = r_o_vld;
    assign o_pp      = r_pp;

    // Appending b[-1] = 0 lets every digit be a plain 3-bit window.
    assign w_b_ext = {i_num_b, 1'b0};

    always_comb begin
        w_dig = '0;
        for (int k = 0; k < 8; k++) begin
            w_dig[k] = w_b_ext[2*k +: 3];
        end
    end

    // 18 bits hold +/-2a for every 16-bit a, including -2 * -32768.
    assign w_a2 = {r_s1_a[16:0], 1'b0};

    always_comb begin
        w_mult = '0;
        w_pp   = '0;
        for (int k = 0; k < 8; k++) begin
            case (r_s1_dig[k])
                3'b001, 3'b010: w_mult[k] = r_s1_a;
                3'b011:         w_mult[k] = w_a2;
                3'b100:         w_mult[k] = -w_a2;
                3'b101, 3'b110: w_mult[k] = -r_s1_a;
                default:        w_mult[k] = '0;
            endcase
            w_pp[k] = {{14{w_mult[k][17]}}, w_mult[k]} << (2*k);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_dig <= '0;
        end else begin
            if (w_in_xfer) begin
                r_s1_vld <= 1'b1;
                r_s1_a   <= {{2{i_num_a[15]}}, i_num_a};
                r_s1_dig <= w_dig;
            end else if (w_s2_load) begin
                r_s1_vld <= 1'b0;
            end
        end
    end

    // o_pp only changes when a real pair moves in, so it never shows bubble garbage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_o_vld <= 1'b0;
            r_pp    <= '0;
        end else if (w_s2_load) begin
            r_o_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_pp <= w_pp;
            end
        end
    end

`ifdef MUL_PPGEN_CNT_EN
    logic [15:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_o_vld && i_rdy) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_mul_16bit_booth_ppgen.sv
// Directed-vector and scoreboard bench for mul_16bit_booth_ppgen.
module tb_mul_16bit_booth_ppgen;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_vld;
    logic         o_rdy;
    logic [15:0]  i_num_a;
    logic [15:0]  i_num_b;
    logic         o_vld;
    logic         i_rdy;
    logic [255:0] o_pp;
`ifdef MUL_PPGEN_CNT_EN
    logic [15:0]  o_cnt;
`endif

    mul_16bit_booth_ppgen dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_vld   (i_vld),
        .o_rdy   (o_rdy),
        .i_num_a (i_num_a),
        .i_num_b (i_num_b),
        .o_vld   (o_vld),
        .i_rdy   (i_rdy),
        .o_pp    (o_pp)
`ifdef MUL_PPGEN_CNT_EN
        ,
        .o_cnt   (o_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0]  a;
        logic [15:0]  b;
        logic [255:0] pp;
    } vec_t;

    typedef struct {
        logic [15:0]  a;
        logic [15:0]  b;
        logic [255:0] pp;
        bit           has_pp;
    } exp_t;

    vec_t vt [8];
    exp_t q [$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_out = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pp_sum(input logic [255:0] p);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 8; k++) s = s + p[32*k +: 32];
        return s;
    endfunction

    function automatic logic [31:0] sprod(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] pr;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        pr = sa * sb;
        return pr;
    endfunction

    // One clock with scoreboard bookkeeping; called at a negedge with inputs already set.
    task automatic cycle(output bit in_x);
        bit   out_x;
        exp_t e;
        #1;
        in_x  = i_vld && o_rdy;
        out_x = o_vld && i_rdy;
        if (out_x) begin
            n_out++;
            if (q.size() == 0) begin
                check("unexpected_out", o_vld, 1'b0);
            end else begin
                e = q.pop_front();
                if (e.has_pp) check("seq_pp", o_pp, e.pp);
                check("seq_sum", pp_sum(o_pp), sprod(e.a, e.b));
            end
        end
        if (in_x) begin
            e.a = i_num_a; e.b = i_num_b; e.pp = '0; e.has_pp = 1'b0;
            q.push_back(e);
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit           in_x;
        bit           prev_stall;
        bit           saw_low;
        logic [255:0] prev_pp;
        int           idx;
        int           cyc;
        int           ia;
        exp_t         e;

        vt[0] = '{16'h0003, 16'h0005, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000000C, 32'h00000003}};
        vt[1] = '{16'hFFFF, 16'hFFFF, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000001}};
        vt[2] = '{16'h8000, 16'h8000, {32'h40000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
        vt[3] = '{16'h0001, 16'h0002, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000004, 32'hFFFFFFFE}};
        vt[4] = '{16'h7FFF, 16'h0003, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0001FFFC, 32'hFFFF8001}};
        vt[5] = '{16'h8000, 16'h0006, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFC0000, 32'h00010000}};
        vt[6] = '{16'h0010, 16'h4000, {32'h00040000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
        vt[7] = '{16'h1234, 16'h8000, {32'hF6E60000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};

        i_rst = 1'b1; i_vld = 1'b0; i_rdy = 1'b1; i_num_a = '0; i_num_b = '0;
        @(negedge i_clk);
        check("rdy_in_reset", o_rdy, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("reset_o_vld", o_vld, 1'b0);
        check("reset_o_pp", o_pp, '0);
        check("reset_o_rdy", o_rdy, 1'b1);
`ifdef MUL_PPGEN_CNT_EN
        check("reset_o_cnt", o_cnt, '0);
`endif

        // Single-pair latency and exact partial products.
        for (int v = 0; v < 8; v++) begin
            i_vld = 1'b1; i_num_a = vt[v].a; i_num_b = vt[v].b; i_rdy = 1'b1;
            #1;
            check("vec_rdy", o_rdy, 1'b1);
            @(posedge i_clk); @(negedge i_clk);
            i_vld = 1'b0;
            check("vec_lat_vld0", o_vld, 1'b0);
            @(posedge i_clk); @(negedge i_clk);
            check("vec_lat_vld1", o_vld, 1'b1);
            check("vec_pp", o_pp, vt[v].pp);
            check("vec_sum", pp_sum(o_pp), sprod(vt[v].a, vt[v].b));
            n_out++;
            @(posedge i_clk); @(negedge i_clk);
        end

        // Four back-to-back pairs with a three-cycle downstream stall.
        idx = 0; cyc = 0; prev_stall = 1'b0; saw_low = 1'b0; prev_pp = '0;
        while ((idx < 4 || q.size() != 0) && cyc < 50) begin
            if (prev_stall) check("stall_hold_pp", o_pp, prev_pp);
            if (cyc >= 5 && q.size() != 0) check("no_gap_vld", o_vld, 1'b1);
            i_rdy = !(cyc >= 2 && cyc <= 4);
            i_vld = (idx < 4);
            if (idx < 4) begin i_num_a = vt[idx].a; i_num_b = vt[idx].b; end
            #1;
            if (!o_rdy) saw_low = 1'b1;
            prev_stall = o_vld && !i_rdy;
            prev_pp = o_pp;
            if (i_vld && o_rdy) begin
                e.a = vt[idx].a; e.b = vt[idx].b; e.pp = vt[idx].pp; e.has_pp = 1'b1;
            end
            cycle(in_x);
            if (in_x) begin
                q[q.size()-1] = e;
                idx++;
            end
            cyc++;
        end
        check("stall_done", (cyc < 50), 1'b1);
        check("stall_rdy_fell", saw_low, 1'b1);
        i_vld = 1'b0; i_rdy = 1'b1;

        // Reset with two pairs in flight.
        idx = 0; cyc = 0; i_rdy = 1'b0;
        while (idx < 2 && cyc < 10) begin
            i_vld = 1'b1; i_num_a = vt[idx+2].a; i_num_b = vt[idx+2].b;
            cycle(in_x);
            if (in_x) idx++;
            cyc++;
        end
        i_vld = 1'b0;
        check("inflight_vld", o_vld, 1'b1);
        i_rst = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        check("midrst_o_vld", o_vld, 1'b0);
        check("midrst_o_pp", o_pp, '0);
        check("midrst_o_rdy", o_rdy, 1'b0);
`ifdef MUL_PPGEN_CNT_EN
        check("midrst_o_cnt", o_cnt, '0);
`endif
        i_rst = 1'b0; i_rdy = 1'b1;
        q.delete();
        n_out = 0;
        for (int c = 0; c < 5; c++) begin
            check("post_rst_idle", o_vld, 1'b0);
            cycle(in_x);
        end

        // Random stream against the signed product.
        ia = 0; cyc = 0;
        while ((ia < 10000 || q.size() != 0) && cyc < 40000) begin
            i_vld = (ia < 10000) && ($urandom_range(0, 3) != 0);
            i_rdy = ($urandom_range(0, 3) != 0);
            i_num_a = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
            i_num_b = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
            cycle(in_x);
            if (in_x) ia++;
            cyc++;
        end
        i_vld = 1'b0;
        check("random_done", (cyc < 40000), 1'b1);
`ifdef MUL_PPGEN_CNT_EN
        check("random_o_cnt", o_cnt, 16'(n_out));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_16bit_booth_ppgen.md
# mul_16bit_booth_ppgen

Two-stage pipelined radix-4 Booth partial-product generator for the 16x16 signed multiplier. It accepts a multiplicand/multiplier pair over a valid/ready handshake and produces eight 32-bit sign-extended, pre-shifted partial products. It sits directly upstream of the 1-bit x 8-input Wallace column array: bit j of every partial product forms the 8-bit column input of Wallace slice j. The sum of the eight products modulo 2^32 equals the signed product.

## Interface
- No parameters; widths are fixed at 16-bit operands, 8 partial products and 32-bit product width.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_vld  in  1  input operand pair valid.
- o_rdy  out  1  block can accept an operand pair this cycle.
- i_num_a  in  16  multiplicand, two's complement.
- i_num_b  in  16  multiplier, two's complement, Booth-recoded.
- o_vld  out  1  o_pp holds a valid set.
- i_rdy  in  1  downstream Wallace stage accepts o_pp.
- o_pp  out  256  partial products; product k occupies [32k+31:32k].
- o_cnt  out  16  number of completed output transfers; present only with MUL_PPGEN_CNT_EN.

## Operation
- Transfer in: i_vld && o_rdy. Transfer out: o_vld && i_rdy.
- Stage 1 (S1) registers i_num_a, sign-extended to 18 bits, and eight 3-bit Booth digit codes. Digit k is taken from bits {b[2k+1], b[2k], b[2k-1]}, with b[-1] = 0.
- Booth map:
  - 000 and 111 -> 0.
  - 001 and 010 -> +1.
  - 011 -> +2.
  - 100 -> -2.
  - 101 and 110 -> -1.
- Stage 2 (S2) registers pp_k = (digit_k * a), sign-extended to 32 bits, then shifted left by 2k and truncated to 32 bits.
  - Negation is full two's complement inside the product. No separate +1 correction bits are emitted.
- Each stage holds a valid bit (s1_vld, o_vld) and forms one elastic pipeline:
  - S2 loads when !o_vld || i_rdy.
  - S1 advances into S2 when S2 loads.
  - o_rdy = !s1_vld || (S2 loads this cycle).
- Under stall (o_vld && !i_rdy), o_pp and S1 contents hold exactly. No data is dropped or duplicated.
- Simultaneous transfer in and out at full occupancy is legal. Throughput is one pair per cycle.
- Reset values: s1_vld = 0, o_vld = 0, o_pp = 0, o_cnt = 0.
  - o_rdy is 1 in the cycle after reset is released.
  - o_rdy is forced to 0 while i_rst is high.
- Reset mid-operation discards every in-flight pair. Nothing is emitted after reset.

## Timing
- Latency: a pair accepted at edge n appears with o_vld = 1 after edge n+1, when S1 and S2 are unstalled.
- o_rdy is combinational from i_rdy, o_vld and s1_vld. There is no combinational path from i_vld, i_num_a or i_num_b to any output.
- o_pp and o_vld are driven directly from registers.
- Extremes such as a = b = 0x8000 and a = 0x8000 with digit -2 wrap modulo 2^32. The final sum must still be correct.

## Configuration
- MUL_PPGEN_CNT_EN defined:
  - o_cnt port exists.
  - o_cnt increments by 1 on every output transfer and wraps from 0xFFFF to 0.
  - Synchronous reset clears it to 0.
- MUL_PPGEN_CNT_EN undefined: o_cnt port and its counter are absent. All other behaviour is identical.

## Test plan
- a = 3, b = 5, i_rdy = 1 -> o_vld two cycles after acceptance; pp0 = 0x00000003, pp1 = 0x0000000C, pp2..pp7 = 0; sum = 15.
- a = 0xFFFF, b = 0xFFFF -> pp0 = 0x00000001, all other products 0; sum = 1.
- a = 0x8000, b = 0x8000 -> pp7 = 0x40000000, all other products 0; sum = 0x40000000.
- Stream 4 pairs back-to-back, i_rdy = 0 for 3 cycles mid-stream -> o_rdy falls after S1 fills; o_pp stable while stalled; all 4 results in order; no gaps once i_rdy = 1.
- Assert i_rst with 2 pairs in flight -> o_vld = 0 and o_pp = 0 next cycle; no stale result afterwards; o_cnt = 0 (CNT_EN build).
- 10,000 random pairs with random i_rdy -> each 32-bit sum of products equals the signed a*b; o_cnt equals the number of output transfers (CNT_EN build).
